// File: rtl/sdram_bridge_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_bridge_pkg : shared states, defaults and fill pattern for the SDRAM bridge
// Revision: 1.0
// ----------------------------------------------------------------------------
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 21;
  localparam int DEF_CW      = 23;
  localparam int DEF_RST_DLY = 3;
  localparam int DEF_TMO     = 1023;

  // Replicated across the data width when a request times out.
  localparam logic TMO_FILL_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/reset_stretch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_stretch : two-flop reset synchroniser plus saturating release delay
// Revision: 1.0
// ----------------------------------------------------------------------------
module reset_stretch
  import sdram_bridge_pkg::*;
#(
  parameter int RST_DLY = DEF_RST_DLY
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rst_req_i,
  output logic srst_o,
  output logic rst_n_o
);

  localparam int             CNW     = $clog2(RST_DLY + 1);
  localparam logic [CNW-1:0] CNT_MAX = CNW'(RST_DLY);

  logic [1:0]     sync_q;
  logic [CNW-1:0] cnt_q;
  logic [CNW-1:0] cnt_d;

  // Flops come out of reset asserted so downstream logic starts held in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rst_req_i};
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (srst_o) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign srst_o  = sync_q[1];
  assign rst_n_o = ~sync_q[1] & (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/sdram_bus_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_bus_bridge : strobe/ack kernel bus to req/ack SDRAM controller bridge
// Revision: 1.0
// ----------------------------------------------------------------------------
module sdram_bus_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int CW      = DEF_CW,
  parameter int RST_DLY = DEF_RST_DLY,
  parameter int TMO     = DEF_TMO
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            sys_reset,
  input  logic            bus_stb,
  input  logic            bus_we,
  input  logic [DW/8-1:0] bus_sel,
  input  logic [AW-1:0]   bus_adr,
  input  logic [DW-1:0]   bus_dout,
  output logic [DW-1:0]   bus_din,
  output logic            bus_ack,
  output logic            bus_ready,
  output logic            ctl_rst_n,
  input  logic            ctl_init_done,
  output logic            ctl_wr_req,
  output logic            ctl_rd_req,
  input  logic            ctl_wr_ack,
  input  logic            ctl_rd_ack,
  output logic [CW-1:0]   ctl_adr,
  output logic [DW-1:0]   ctl_wdat,
  input  logic [DW-1:0]   ctl_rdat,
  output logic [DW/8-1:0] ctl_dm,
  output logic            tmo_err
);

  localparam int            SW       = DW / 8;
  localparam int            TW       = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TMO > 0) ? TW'(TMO - 1) : '0;
  localparam logic [TW-1:0] TMR_MAX  = (TMO > 0) ? TW'(TMO) : '0;

  logic          srst;
  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] din_q, din_d;
  logic [SW-1:0] dm_q, dm_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q;
  logic          w_ack_match;
  logic          w_tmo_hit;
  logic          w_reply;

  reset_stretch #(
    .RST_DLY (RST_DLY)
  ) u_reset_stretch (
    .clk_i     (clk_p),
    .rst_ni    (rst_n),
    .rst_req_i (sys_reset),
    .srst_o    (srst),
    .rst_n_o   (ctl_rst_n)
  );

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      din_q   <= '0;
      dm_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      din_q   <= din_d;
      dm_q    <= dm_d;
      we_q    <= we_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      ready_q <= ctl_init_done;
    end
  end

  assign w_ack_match = we_q ? ctl_wr_ack : ctl_rd_ack;
  // Timer holds the number of REQ cycles already spent, so the limit fires on the TMO-th.
  assign w_tmo_hit   = (TMO != 0) && (timer_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    din_d   = din_q;
    dm_d    = dm_q;
    we_d    = we_q;
    err_d   = err_q;
    timer_d = timer_q;
    if (srst) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_stb && ctl_init_done) begin
            adr_d   = bus_adr;
            wdat_d  = bus_dout;
            we_d    = bus_we;
            dm_d    = bus_we ? ~bus_sel : '0;
            timer_d = '0;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack_match) begin
            if (!we_q) begin
              din_d = ctl_rdat;
            end
            state_d = S_DONE;
          end else if (w_tmo_hit) begin
            din_d   = {DW{TMO_FILL_BIT}};
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!bus_stb) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Requests and reply are gated by srst so a reset cuts them off without waiting an edge.
  assign ctl_wr_req = (state_q == S_REQ) & we_q & ~srst;
  assign ctl_rd_req = (state_q == S_REQ) & ~we_q & ~srst;
  assign w_reply    = (state_q == S_DONE) & ~srst;
  assign bus_ack    = bus_stb & w_reply;

  assign bus_din   = din_q;
  assign bus_ready = ready_q;
  assign ctl_adr   = CW'(adr_q);
  assign ctl_wdat  = wdat_q;
  assign ctl_dm    = dm_q;
  assign tmo_err   = err_q;

endmodule
`default_nettype wire
